// File: rtl/bus_pkg.sv
// Shared encodings for the host-to-system_bus request slice: FSM states,
// access kinds and the default error read data.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // KIND_BOTH marks a simultaneous read+write request; it travels as a write.
   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_READ  = 2'd1,
      KIND_WRITE = 2'd2,
      KIND_BOTH  = 2'd3
   } kind_t;

   localparam logic [31:0] DEFAULT_ERROR_READ_DATA = 32'h0000_0000;
   localparam int          TIMER_W                 = 16;

   function automatic kind_t decode_kind(input logic rd, input logic wr);
      if (rd && wr)
         return KIND_BOTH;
      else if (wr)
         return KIND_WRITE;
      else
         return KIND_READ;
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// WAIT-state cycle counter: clears on demand, counts while enabled and
// flags when the count equals TERMINAL.
module bus_timeout_counter
   import bus_pkg::*;
#(
   parameter int unsigned TERMINAL = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [TIMER_W-1:0] TERMINAL_COUNT = TIMER_W'(TERMINAL);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + TIMER_W'(1);
   end

   assign terminal = (count == TERMINAL_COUNT);

endmodule

// File: rtl/bus_request_slice.sv
// Registered request/response slice between the RV32 host port and system_bus.
// Define BUS_TIMEOUT_EN to terminate hung transactions after TIMEOUT_CYCLES.
module bus_request_slice
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES  = 256,
   parameter logic [31:0] ERROR_READ_DATA = DEFAULT_ERROR_READ_DATA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] host_rw_address,
   output logic [31:0] host_read_data,
   input  logic        host_read_request,
   output logic        host_read_response,
   input  logic [31:0] host_write_data,
   input  logic [3:0]  host_write_strobe,
   input  logic        host_write_request,
   output logic        host_write_response,
   output logic        host_busy,
   output logic [31:0] bus_rw_address,
   input  logic [31:0] bus_read_data,
   output logic        bus_read_request,
   input  logic        bus_read_response,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_write_strobe,
   output logic        bus_write_request,
   input  logic        bus_write_response,
   output logic        timeout_error
);

   state_t state;
   kind_t  kind;
   logic   resp_hit;
   logic   timed_out;

   // A write or simultaneous request only completes on a write response.
   assign resp_hit = (kind == KIND_READ) ? bus_read_response : bus_write_response;

`ifdef BUS_TIMEOUT_EN
   logic timer_clear;
   logic timer_enable;
   logic timer_terminal;

   assign timer_clear  = (state == ST_ISSUE);
   assign timer_enable = (state == ST_WAIT) && !resp_hit;
   assign timed_out    = (state == ST_WAIT) && !resp_hit && timer_terminal;

   bus_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_timeout_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .terminal (timer_terminal)
   );
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign timed_out          = 1'b0;
   assign timeout_error      = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state               <= ST_IDLE;
         kind                <= KIND_NONE;
         host_busy           <= 1'b0;
         host_read_response  <= 1'b0;
         host_write_response <= 1'b0;
         host_read_data      <= '0;
         bus_rw_address      <= '0;
         bus_write_data      <= '0;
         bus_write_strobe    <= '0;
         bus_read_request    <= 1'b0;
         bus_write_request   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         timeout_error       <= 1'b0;
`endif
      end else begin
         bus_read_request    <= 1'b0;
         bus_write_request   <= 1'b0;
         host_read_response  <= 1'b0;
         host_write_response <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         timeout_error       <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (host_read_request || host_write_request) begin
                  bus_rw_address    <= host_rw_address;
                  bus_write_data    <= host_write_data;
                  bus_write_strobe  <= host_write_strobe;
                  kind              <= decode_kind(host_read_request, host_write_request);
                  bus_read_request  <= host_read_request && !host_write_request;
                  bus_write_request <= host_write_request;
                  host_busy         <= 1'b1;
                  state             <= ST_ISSUE;
               end
            end

            ST_ISSUE: state <= ST_WAIT;

            ST_WAIT: begin
               if (resp_hit || timed_out) begin
                  host_read_response  <= (kind != KIND_WRITE);
                  host_write_response <= (kind != KIND_READ);
                  if (kind == KIND_READ)
                     host_read_data <= resp_hit ? bus_read_data : ERROR_READ_DATA;
                  else if (kind == KIND_BOTH)
                     host_read_data <= ERROR_READ_DATA;
                  host_busy <= 1'b0;
                  state     <= ST_IDLE;
`ifdef BUS_TIMEOUT_EN
                  timeout_error <= !resp_hit;
`endif
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_request_slice.sv
// Directed table-driven bench for bus_request_slice plus hand-written
// sequences for busy, mismatch, async reset and timeout corners.
module tb_bus_request_slice;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] host_rw_address = '0;
   logic [31:0] host_read_data;
   logic        host_read_request = 1'b0;
   logic        host_read_response;
   logic [31:0] host_write_data = '0;
   logic [3:0]  host_write_strobe = '0;
   logic        host_write_request = 1'b0;
   logic        host_write_response;
   logic        host_busy;
   logic [31:0] bus_rw_address;
   logic [31:0] bus_read_data = '0;
   logic        bus_read_request;
   logic        bus_read_response = 1'b0;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_write_strobe;
   logic        bus_write_request;
   logic        bus_write_response = 1'b0;
   logic        timeout_error;

   int tests  = 0;
   int failed = 0;

   always #5 clock = ~clock;

   bus_request_slice #(
      .TIMEOUT_CYCLES  (8),
      .ERROR_READ_DATA (32'h0000_0000)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .host_rw_address     (host_rw_address),
      .host_read_data      (host_read_data),
      .host_read_request   (host_read_request),
      .host_read_response  (host_read_response),
      .host_write_data     (host_write_data),
      .host_write_strobe   (host_write_strobe),
      .host_write_request  (host_write_request),
      .host_write_response (host_write_response),
      .host_busy           (host_busy),
      .bus_rw_address      (bus_rw_address),
      .bus_read_data       (bus_read_data),
      .bus_read_request    (bus_read_request),
      .bus_read_response   (bus_read_response),
      .bus_write_data      (bus_write_data),
      .bus_write_strobe    (bus_write_strobe),
      .bus_write_request   (bus_write_request),
      .bus_write_response  (bus_write_response),
      .timeout_error       (timeout_error)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          delay;
      logic [31:0] bus_rdata;
      logic        busy_poke;
      logic        exp_bus_rd;
      logic        exp_bus_wr;
      logic        exp_rresp;
      logic        exp_wresp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue_read(input logic [31:0] addr);
      step();
      host_rw_address   = addr;
      host_read_request = 1'b1;
      @(negedge clock);
      step();
      host_read_request = 1'b0;
      @(negedge clock);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int bus_req_seen;
      int host_resp_seen;
      string tag;
      tag = $sformatf("v%0d", idx);
      step();
      host_rw_address    = v.addr;
      host_write_data    = v.wdata;
      host_write_strobe  = v.strb;
      host_read_request  = v.rd;
      host_write_request = v.wr;
      @(negedge clock);
      chk1({tag, "_idle_busy"}, host_busy, 1'b0);
      step();
      host_read_request  = v.busy_poke;
      host_write_request = 1'b0;
      @(negedge clock);
      chk1({tag, "_bus_rd_req"}, bus_read_request, v.exp_bus_rd);
      chk1({tag, "_bus_wr_req"}, bus_write_request, v.exp_bus_wr);
      chk({tag, "_bus_addr"}, bus_rw_address, v.addr);
      chk({tag, "_bus_wdata"}, bus_write_data, v.wdata);
      chk({tag, "_bus_strb"}, {28'd0, bus_write_strobe}, {28'd0, v.strb});
      chk1({tag, "_busy"}, host_busy, 1'b1);
      bus_req_seen   = 0;
      host_resp_seen = 0;
      for (int i = 1; i < v.delay; i++) begin
         step();
         host_read_request = v.busy_poke;
         @(negedge clock);
         bus_req_seen   += int'(bus_read_request) + int'(bus_write_request);
         host_resp_seen += int'(host_read_response) + int'(host_write_response);
      end
      step();
      bus_read_response  = v.rd && !v.wr;
      bus_write_response = v.wr;
      bus_read_data      = v.bus_rdata;
      @(negedge clock);
      bus_req_seen   += int'(bus_read_request) + int'(bus_write_request);
      host_resp_seen += int'(host_read_response) + int'(host_write_response);
      chk({tag, "_extra_bus_req"}, 32'(bus_req_seen), 32'd0);
      chk({tag, "_early_resp"}, 32'(host_resp_seen), 32'd0);
      step();
      bus_read_response  = 1'b0;
      bus_write_response = 1'b0;
      bus_read_data      = '0;
      host_read_request  = 1'b0;
      @(negedge clock);
      chk1({tag, "_rresp"}, host_read_response, v.exp_rresp);
      chk1({tag, "_wresp"}, host_write_response, v.exp_wresp);
      chk({tag, "_rdata"}, host_read_data, v.exp_rdata);
      chk1({tag, "_busy_done"}, host_busy, 1'b0);
      chk1({tag, "_no_timeout"}, timeout_error, 1'b0);
      step();
      @(negedge clock);
      chk({tag, "_single_pulse"}, {30'd0, host_read_response, host_write_response}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      //                rd    wr    addr            wdata           strb     dly bus_rdata      poke  bRd   bWr   rRsp  wRsp  rdata
      vecs[0] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'b0000, 1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
      vecs[1] = '{1'b0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'b0011, 3, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'b0000, 4, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1111_2222, 4'b1111, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'b0000, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};

      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk1("rst_busy", host_busy, 1'b0);
      chk1("rst_bus_rd", bus_read_request, 1'b0);
      chk1("rst_bus_wr", bus_write_request, 1'b0);
      chk("rst_addr", bus_rw_address, 32'd0);
      chk("rst_rdata", host_read_data, 32'd0);
      chk1("rst_timeout", timeout_error, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++)
         run_vec(vecs[i], i);

      // Response of the wrong kind must not complete a read.
      issue_read(32'h0000_0400);
      step();
      bus_write_response = 1'b1;
      @(negedge clock);
      step();
      bus_write_response = 1'b0;
      @(negedge clock);
      chk1("mismatch_rresp", host_read_response, 1'b0);
      chk1("mismatch_busy", host_busy, 1'b1);
      step();
      bus_read_response = 1'b1;
      bus_read_data     = 32'h0BAD_F00D;
      @(negedge clock);
      step();
      bus_read_response = 1'b0;
      bus_read_data     = '0;
      @(negedge clock);
      chk1("mismatch_final_rresp", host_read_response, 1'b1);
      chk("mismatch_final_rdata", host_read_data, 32'h0BAD_F00D);

      // Bus response while idle is discarded.
      step();
      bus_read_response = 1'b1;
      bus_read_data     = 32'hFFFF_0000;
      @(negedge clock);
      step();
      bus_read_response = 1'b0;
      bus_read_data     = '0;
      @(negedge clock);
      chk1("idle_resp_rresp", host_read_response, 1'b0);
      chk("idle_resp_rdata", host_read_data, 32'h0BAD_F00D);

      // Asynchronous reset in WAIT.
      step();
      host_rw_address   = 32'h8000_0040;
      host_write_data   = 32'h0000_0055;
      host_write_strobe = 4'hF;
      host_read_request = 1'b1;
      @(negedge clock);
      step();
      host_read_request = 1'b0;
      step();
      #2 reset = 1'b1;
      #1;
      chk1("arst_busy", host_busy, 1'b0);
      chk("arst_addr", bus_rw_address, 32'd0);
      chk("arst_wdata", bus_write_data, 32'd0);
      chk("arst_strb", {28'd0, bus_write_strobe}, 32'd0);
      chk("arst_rdata", host_read_data, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      step();
      bus_read_response = 1'b1;
      bus_read_data     = 32'h7777_7777;
      @(negedge clock);
      step();
      bus_read_response = 1'b0;
      bus_read_data     = '0;
      @(negedge clock);
      chk1("arst_dropped_rresp", host_read_response, 1'b0);
      chk("arst_dropped_rdata", host_read_data, 32'd0);
      run_vec(vecs[0], 10);

`ifdef BUS_TIMEOUT_EN
      issue_read(32'h8000_0080);
      seen = 0;
      for (int i = 2; i <= 9; i++) begin
         step();
         @(negedge clock);
         seen += int'(host_read_response) + int'(timeout_error);
      end
      chk("to_early", 32'(seen), 32'd0);
      step();
      @(negedge clock);
      chk1("to_rresp", host_read_response, 1'b1);
      chk1("to_error", timeout_error, 1'b1);
      chk("to_rdata", host_read_data, 32'h0000_0000);
      chk1("to_busy", host_busy, 1'b0);
      step();
      bus_read_response = 1'b1;
      bus_read_data     = 32'hFEED_FEED;
      @(negedge clock);
      step();
      bus_read_response = 1'b0;
      bus_read_data     = '0;
      @(negedge clock);
      chk1("to_late_rresp", host_read_response, 1'b0);
      chk("to_late_rdata", host_read_data, 32'h0000_0000);
`else
      issue_read(32'h8000_0080);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         @(negedge clock);
         seen += int'(host_read_response) + int'(timeout_error) + int'(!host_busy);
      end
      chk("hold_wait", 32'(seen), 32'd0);
      step();
      bus_read_response = 1'b1;
      bus_read_data     = 32'h0F0F_A5A5;
      @(negedge clock);
      step();
      bus_read_response = 1'b0;
      bus_read_data     = '0;
      @(negedge clock);
      chk1("hold_rresp", host_read_response, 1'b1);
      chk("hold_rdata", host_read_data, 32'h0F0F_A5A5);
      chk1("hold_no_timeout", timeout_error, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
